// File: rtl/apb_slave_mem_pkg.sv
// Shared APB definitions: bus widths, select width and responder FSM encoding.
package apb_pkg;
  localparam int APB_AW = 32;
  localparam int APB_DW = 32;
  localparam int PSEL_W = 3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  typedef logic [APB_AW-1:0] apb_addr_t;
  typedef logic [APB_DW-1:0] apb_data_t;
endpackage

// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between the bridge (master) and a responder (slave).
interface apb_slave_mem_if;
  import apb_pkg::*;

  logic [PSEL_W-1:0] psel;
  logic              penable;
  logic              pwrite;
  apb_addr_t         paddr;
  apb_data_t         pwdata;
  apb_data_t         pr_data;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pr_data, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pr_data, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_mem_regfile.sv
// DEPTH x 32 word store: one write port, one registered read port, synchronous clear.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  apb_data_t     i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output apb_data_t     o_rdata
);
  apb_data_t r_mem [DEPTH];
  apb_data_t r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rdata <= '0;
    end else begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/apb_slave_mem.sv
// APB responder for one psel line: word-addressed memory window with
// configurable wait states and pslverr on out-of-window accesses.
//
//   state  | meaning
//   IDLE   | waiting for a setup phase on our psel bit
//   SETUP  | setup seen; address/data latched when access phase begins
//   ACCESS | counting wait states; pready when the counter reaches zero
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int          SEL_IDX     = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH       = 16,
  parameter int          WAIT_STATES = 0
) (
  input logic             hclk,
  input logic             hreset,
  apb_slave_mem_if.slave  apb
);
  localparam int        IDX_W     = $clog2(DEPTH);
  localparam logic [3:0] WS       = 4'(WAIT_STATES);
  localparam apb_addr_t WIN_BYTES = apb_addr_t'(4 * DEPTH);

  logic [1:0]       r_state;
  logic [3:0]       r_wcnt;
  logic             r_pwrite;
  logic             r_hit;
  logic [IDX_W-1:0] r_idx;
  apb_data_t        r_pwdata;

  logic      w_sel;
  logic      w_hit;
  logic      w_setup_go;
  logic      w_done;
  logic      w_we;
  logic      w_re;
  apb_addr_t w_off;
  apb_data_t w_rdata;

  assign w_sel      = apb.psel[SEL_IDX];
  assign w_off      = apb.paddr - BASE_ADDR;
  // Lower-bound compare first so the wrapped offset never aliases into the window.
  assign w_hit      = (apb.paddr >= BASE_ADDR) && (w_off < WIN_BYTES);
  assign w_setup_go = (r_state == ST_SETUP) && w_sel && apb.penable;
  assign w_done     = (r_state == ST_ACCESS) && (r_wcnt == 4'd0);
  assign w_we       = w_done && r_pwrite && r_hit;
  assign w_re       = w_setup_go && !apb.pwrite && w_hit;

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state  <= ST_IDLE;
      r_wcnt   <= '0;
      r_pwrite <= 1'b0;
      r_hit    <= 1'b0;
      r_idx    <= '0;
      r_pwdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_sel && !apb.penable) r_state <= ST_SETUP;
        end
        ST_SETUP: begin
          if (!w_sel) begin
            r_state <= ST_IDLE;
          end else if (apb.penable) begin
            r_state  <= ST_ACCESS;
            r_wcnt   <= WS;
            r_pwrite <= apb.pwrite;
            r_hit    <= w_hit;
            r_idx    <= w_off[IDX_W+1:2];
            r_pwdata <= apb.pwdata;
          end
        end
        ST_ACCESS: begin
          if (r_wcnt == 4'd0)
            r_state <= (w_sel && !apb.penable) ? ST_SETUP : ST_IDLE;
          else if (w_sel && apb.penable)
            r_wcnt <= r_wcnt - 4'd1;
          else
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  apb_slave_regfile #(
    .DEPTH (DEPTH),
    .AW    (IDX_W)
  ) u_regfile (
    .i_clk   (hclk),
    .i_rst   (hreset),
    .i_we    (w_we),
    .i_waddr (r_idx),
    .i_wdata (r_pwdata),
    .i_re    (w_re),
    .i_raddr (w_off[IDX_W+1:2]),
    .o_rdata (w_rdata)
  );

  assign apb.pready  = w_done;
  assign apb.pslverr = w_done && !r_hit;
  assign apb.pr_data = (w_done && !r_pwrite && r_hit) ? w_rdata : '0;
endmodule
